// File: rtl/button_debouncer_pkg.sv
// button_debouncer_pkg: shared state type and 50 MHz default timing constants for the button debouncer.
package button_debouncer_pkg;

   typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_e;

   localparam int DEBOUNCE_CYCLES_50MHZ   = 500000;
   localparam int LONG_PRESS_CYCLES_50MHZ = 50000000;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: multi-flop synchronizer for a single asynchronous input bit.
module bit_synchronizer #(
   parameter int   Stages     = 2,
   parameter logic ResetValue = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [Stages-1:0] q;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) q <= {Stages{ResetValue}};
      else         q <= {q[Stages-2:0], d_i};

   assign q_o = q[Stages-1];

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces an active-low pad into a level plus press/release strobes.
// Define BUTTON_DEBOUNCER_LONG_PRESS_EN to add the long_press_o hold strobe.
module button_debouncer
   import button_debouncer_pkg::*;
#(
   parameter int DebounceCycles  = DEBOUNCE_CYCLES_50MHZ,
   parameter int SyncStages      = 2,
   parameter int LongPressCycles = LONG_PRESS_CYCLES_50MHZ
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_ni,
   output logic btn_o,
   output logic press_o,
   output logic release_o,
   output logic long_press_o
);

   localparam int            CW      = $clog2(max_int(DebounceCycles, LongPressCycles) + 1);
   localparam logic [CW-1:0] ONE     = CW'(1);
   localparam logic [CW-1:0] DB_LAST = CW'(DebounceCycles - 1);

   logic          btn_sync, s;
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          btn_q, btn_d, press_q, press_d, rel_q, rel_d;

   // Pad idles high, so the synchronizer resets to "released".
   bit_synchronizer #(.Stages(SyncStages), .ResetValue(1'b1)) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (btn_ni),
      .q_o   (btn_sync)
   );

   assign s = ~btn_sync;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= btn_d;
         press_q <= press_d;
         rel_q   <= rel_d;
      end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      btn_d   = btn_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      unique case (state_q)
         IDLE:
            if (s) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         PRESS_WAIT:
            if (!s) state_d = IDLE;
            else if (cnt_q == DB_LAST) begin
               state_d = PRESSED;
               btn_d   = 1'b1;
               press_d = 1'b1;
            end else cnt_d = cnt_q + ONE;
         PRESSED:
            if (!s) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         RELEASE_WAIT:
            if (s) state_d = PRESSED;
            else if (cnt_q == DB_LAST) begin
               state_d = IDLE;
               btn_d   = 1'b0;
               rel_d   = 1'b1;
            end else cnt_d = cnt_q + ONE;
      endcase
   end

   assign btn_o     = btn_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam logic [CW-1:0] LP_LAST = CW'(LongPressCycles - 1);
   localparam logic [CW-1:0] LP_SAT  = CW'(LongPressCycles);

   logic [CW-1:0] hold_q, hold_d;
   logic          long_q, long_d;

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end

   // Held while a release glitch is pending; saturating past the strobe keeps it one-shot.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (state_q == PRESSED) begin
         hold_d = (hold_q == LP_SAT) ? hold_q : hold_q + ONE;
         long_d = (hold_q == LP_LAST);
      end else if (state_q == IDLE || state_q == PRESS_WAIT) hold_d = '0;
   end

   assign long_press_o = long_q;
`else
   assign long_press_o = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed and randomized checks of button_debouncer against a run-length reference model.
module tb_button_debouncer;

   localparam int DB = 4;
   localparam int SS = 2;
   localparam int LP = 10;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
   localparam int LONG_EXP = 1;
`else
   localparam int LONG_EXP = 0;
`endif

   logic clk = 1'b0, rst_n = 1'b0, btn_n = 1'b0;
   logic btn, press, rel, lp;
   int   total = 0, bad = 0;
   int   n_press = 0, n_rel = 0, n_long = 0;

   button_debouncer #(.DebounceCycles(DB), .SyncStages(SS), .LongPressCycles(LP)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .btn_ni      (btn_n),
      .btn_o       (btn),
      .press_o     (press),
      .release_o   (rel),
      .long_press_o(lp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: the level flips once DB+1 consecutive synchronized samples disagree with it.
   bit pad_h[SS];
   int run, hold;
   bit lvl, s_m;
   bit e_btn, e_press, e_rel, e_long;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int i = 0; i < SS; i++) pad_h[i] = 1'b1;
         lvl = 0; run = 0; hold = 0;
         e_btn = 0; e_press = 0; e_rel = 0; e_long = 0;
      end else begin
         s_m = !pad_h[SS-1];
         e_press = 0; e_rel = 0; e_long = 0;
         if (lvl && run == 0) begin
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
            e_long = (hold == LP - 1);
`endif
            if (hold < LP) hold++;
         end
         if (!lvl) hold = 0;
         if (s_m != lvl) begin
            run++;
            if (run == DB + 1) begin
               lvl = s_m; run = 0;
               e_press = s_m; e_rel = !s_m;
            end
         end else run = 0;
         e_btn = lvl;
         for (int i = SS - 1; i > 0; i--) pad_h[i] = pad_h[i-1];
         pad_h[0] = btn_n;
      end

   always @(negedge clk) begin
      chk("btn_o", btn, e_btn);
      chk("press_o", press, e_press);
      chk("release_o", rel, e_rel);
      chk("long_press_o", lp, e_long);
      chk("press_release_excl", press & rel, 0);
      if (press) n_press++;
      if (rel) n_rel++;
      if (lp) n_long++;
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int p0, r0, l0, len;

   initial begin
      // Reset held with the pad low
      step(3);
      chk("rst_btn", btn, 0);
      chk("rst_press", press, 0);
      chk("rst_long", lp, 0);
      btn_n = 1'b1;
      rst_n = 1'b1;
      step(10);

      // Clean press: fall before edge 1, accepted on edge 7
      btn_n = 1'b0;
      step(6);
      chk("press_edge6_btn", btn, 0);
      chk("press_edge6_press", press, 0);
      step();
      chk("press_edge7_btn", btn, 1);
      chk("press_edge7_press", press, 1);
      l0 = n_long;
      step();
      chk("press_edge8_press", press, 0);
      chk("press_edge8_btn", btn, 1);

      // Long press: strobe 10 cycles after press_o, once per press
      step(8);
      chk("long_edge9", lp, 0);
      step();
      chk("long_edge10", lp, LONG_EXP);
      step(20);
      chk("long_count", n_long - l0, LONG_EXP);

      // Release glitch of 2 cycles is ignored
      r0 = n_rel;
      btn_n = 1'b1;
      step(2);
      btn_n = 1'b0;
      step(12);
      chk("glitch_btn", btn, 1);
      chk("glitch_no_release", n_rel - r0, 0);

      // Sustained release: accepted on edge 7
      btn_n = 1'b1;
      step(6);
      chk("rel_edge6", rel, 0);
      step();
      chk("rel_edge7_rel", rel, 1);
      chk("rel_edge7_btn", btn, 0);
      step(10);

      // Bounce: five 3-cycle lows, then a held fall
      p0 = n_press;
      for (int k = 0; k < 5; k++) begin
         btn_n = 1'b0;
         step(3);
         btn_n = 1'b1;
         step(3);
      end
      chk("bounce_no_press", n_press - p0, 0);
      btn_n = 1'b0;
      step(6);
      chk("bounce_edge6", press, 0);
      step();
      chk("bounce_edge7", press, 1);
      step(3);
      chk("bounce_one_press", n_press - p0, 1);

      // Reset mid-wait, then mid-pressed; no release follows
      btn_n = 1'b1;
      step(12);
      btn_n = 1'b0;
      step(4);
      rst_n = 1'b0;
      #1;
      chk("rst_wait_btn", btn, 0);
      step(2);
      rst_n = 1'b1;
      step(12);
      chk("rst_repress_btn", btn, 1);
      rst_n = 1'b0;
      #1;
      chk("rst_pressed_btn", btn, 0);
      chk("rst_pressed_rel", rel, 0);
      btn_n = 1'b1;
      step(2);
      r0 = n_rel;
      rst_n = 1'b1;
      step(20);
      chk("rst_no_release", n_rel - r0, 0);

      // Randomized pad activity with occasional resets
      for (int k = 0; k < 400; k++) begin
         btn_n = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 16);
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            step($urandom_range(1, 3));
            rst_n = 1'b1;
         end
         step(len);
      end
      step(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
